axi_lite_rr_arbiter: RTL and testbench

- Round-robin transaction scheduler for the AXI4-Lite interconnect.
- Watches the AR/AW valid lines and addresses of all masters and picks one master and one transaction kind (read or write).
- Decodes the picked address against the slave address map and holds the grant until the datapath reports completion, or until a watchdog timeout fires.
- Drives the mux/demux selects of the interconnect datapath, replacing the fixed-priority select logic.

---
 rtl/axi_lite_rr_arbiter.sv | 203 ++++++++++++++++++++
 tb/tb_axi_lite_rr_arbiter.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_lite_rr_arbiter.sv
// Round-robin read/write transaction scheduler for the AXI4-Lite interconnect.
// Picks one master and one transaction kind, decodes the slave, holds the
// grant until the datapath reports completion or the watchdog aborts it.
module axi_lite_rr_arbiter #(
  parameter int unsigned NUM_MASTER     = 2,
  parameter int unsigned NUM_SLAVE      = 2,
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter logic [NUM_SLAVE*ADDR_WIDTH-1:0] SLAVE_BASE  = {32'h10, 32'h0},
  parameter logic [NUM_SLAVE*ADDR_WIDTH-1:0] SLAVE_LIMIT = {32'h20, 32'h10},
  parameter int unsigned TIMEOUT_CYCLES = 256,
  localparam int unsigned MW = $clog2(NUM_MASTER),
  localparam int unsigned SW = (NUM_SLAVE > 1) ? $clog2(NUM_SLAVE) : 1
) (
  input  logic                             aclk,
  input  logic                             areset,
  input  logic [NUM_MASTER-1:0]            m_arvalid,
  input  logic [NUM_MASTER-1:0]            m_awvalid,
  input  logic [NUM_MASTER*ADDR_WIDTH-1:0] m_araddr,
  input  logic [NUM_MASTER*ADDR_WIDTH-1:0] m_awaddr,
  input  logic                             r_done,
  input  logic                             b_done,
  output logic                             grant_valid,
  output logic [MW-1:0]                    grant_m,
  output logic [SW-1:0]                    grant_s,
  output logic                             grant_write,
  output logic                             grant_decerr,
  output logic                             timeout
);

  // Watchdog counter sizing; a zero limit disables the watchdog entirely.
  localparam int unsigned CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CW-1:0] CNT_MAX  = '1;
  localparam logic [CW-1:0] CNT_LAST = (TIMEOUT_CYCLES > 0) ? CW'(TIMEOUT_CYCLES - 1) : '0;
  localparam bit            WDOG_EN  = (TIMEOUT_CYCLES != 0);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [MW-1:0]   ptr_q, ptr_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            grant_valid_q, grant_valid_d;
  logic [MW-1:0]   grant_m_q, grant_m_d;
  logic [SW-1:0]   grant_s_q, grant_s_d;
  logic            grant_write_q, grant_write_d;
  logic            grant_decerr_q, grant_decerr_d;
  logic            timeout_q, timeout_d;

  logic [NUM_MASTER-1:0] req_c;
  int unsigned           arb_idx_c;
  logic [MW-1:0]         arb_cand_c;
  logic                  win_found_c;
  logic [MW-1:0]         win_c;
  logic                  win_read_c;
  logic [ADDR_WIDTH-1:0] win_addr_c;
  logic                  dec_hit_c;
  logic [SW-1:0]         dec_s_c;
  logic                  done_c;
  logic                  timeout_hit_c;

  assign req_c = m_arvalid | m_awvalid;

  // Round-robin search starting at ptr_q, wrapping modulo NUM_MASTER.
  always_comb begin
    arb_idx_c   = 0;
    arb_cand_c  = '0;
    win_found_c = 1'b0;
    win_c       = '0;
    for (int unsigned j = 0; j < NUM_MASTER; j++) begin
      arb_idx_c  = (32'(ptr_q) + j) % NUM_MASTER;
      arb_cand_c = MW'(arb_idx_c);
      if (!win_found_c && req_c[arb_cand_c]) begin
        win_found_c = 1'b1;
        win_c       = arb_cand_c;
      end
    end
  end

  // Kind selection (read preferred) and address of the winning master.
  always_comb begin
    win_read_c = m_arvalid[win_c];
    win_addr_c = win_read_c ? m_araddr[32'(win_c)*ADDR_WIDTH +: ADDR_WIDTH]
                            : m_awaddr[32'(win_c)*ADDR_WIDTH +: ADDR_WIDTH];
  end

  // Address decode; the lowest matching slave index wins.
  always_comb begin
    dec_hit_c = 1'b0;
    dec_s_c   = '0;
    for (int unsigned i = 0; i < NUM_SLAVE; i++) begin
      if (!dec_hit_c &&
          (win_addr_c >= SLAVE_BASE[i*ADDR_WIDTH +: ADDR_WIDTH]) &&
          (win_addr_c <  SLAVE_LIMIT[i*ADDR_WIDTH +: ADDR_WIDTH])) begin
        dec_hit_c = 1'b1;
        dec_s_c   = SW'(i);
      end
    end
  end

  // Completion of the held transaction and watchdog expiry (done wins a tie).
  always_comb begin
    done_c        = ((state_q == ST_READ) && r_done) || ((state_q == ST_WRITE) && b_done);
    timeout_hit_c = WDOG_EN && (state_q != ST_IDLE) && (cnt_q == CNT_LAST) && !done_c;
  end

  // State register.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (win_found_c) begin
          state_d = win_read_c ? ST_READ : ST_WRITE;
        end
      end
      ST_READ, ST_WRITE: begin
        if (done_c || timeout_hit_c) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output/datapath next values: latch selects at grant, run the watchdog while busy.
  always_comb begin
    ptr_d          = ptr_q;
    cnt_d          = cnt_q;
    grant_m_d      = grant_m_q;
    grant_s_d      = grant_s_q;
    grant_write_d  = grant_write_q;
    grant_decerr_d = grant_decerr_q;
    timeout_d      = 1'b0;
    grant_valid_d  = (state_d != ST_IDLE);
    unique case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (win_found_c) begin
          grant_m_d      = win_c;
          grant_s_d      = dec_s_c;
          grant_write_d  = !win_read_c;
          grant_decerr_d = !dec_hit_c;
          ptr_d          = (win_c == MW'(NUM_MASTER - 1)) ? '0 : win_c + MW'(1);
        end
      end
      ST_READ, ST_WRITE: begin
        if (done_c) begin
          cnt_d = '0;
        end else if (timeout_hit_c) begin
          cnt_d     = '0;
          timeout_d = 1'b1;
        end else begin
          cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CW'(1);
        end
      end
      default: begin
        cnt_d = '0;
      end
    endcase
  end

  // Registered outputs, pointer and watchdog counter.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      ptr_q          <= '0;
      cnt_q          <= '0;
      grant_valid_q  <= 1'b0;
      grant_m_q      <= '0;
      grant_s_q      <= '0;
      grant_write_q  <= 1'b0;
      grant_decerr_q <= 1'b0;
      timeout_q      <= 1'b0;
    end else begin
      ptr_q          <= ptr_d;
      cnt_q          <= cnt_d;
      grant_valid_q  <= grant_valid_d;
      grant_m_q      <= grant_m_d;
      grant_s_q      <= grant_s_d;
      grant_write_q  <= grant_write_d;
      grant_decerr_q <= grant_decerr_d;
      timeout_q      <= timeout_d;
    end
  end

  assign grant_valid  = grant_valid_q;
  assign grant_m      = grant_m_q;
  assign grant_s      = grant_s_q;
  assign grant_write  = grant_write_q;
  assign grant_decerr = grant_decerr_q;
  assign timeout      = timeout_q;

endmodule

// File: tb/tb_axi_lite_rr_arbiter.sv
// Directed self-checking bench for axi_lite_rr_arbiter (watchdog limit 8).
module tb_axi_lite_rr_arbiter;

  localparam int unsigned NM = 2;
  localparam int unsigned AW = 32;

  logic            aclk;
  logic            areset;
  logic [NM-1:0]   m_arvalid;
  logic [NM-1:0]   m_awvalid;
  logic [NM*AW-1:0] m_araddr;
  logic [NM*AW-1:0] m_awaddr;
  logic            r_done;
  logic            b_done;
  logic            grant_valid;
  logic [0:0]      grant_m;
  logic [0:0]      grant_s;
  logic            grant_write;
  logic            grant_decerr;
  logic            timeout;

  int n_checks = 0;
  int n_fail   = 0;

  axi_lite_rr_arbiter #(
    .NUM_MASTER    (2),
    .NUM_SLAVE     (2),
    .ADDR_WIDTH    (32),
    .SLAVE_BASE    ({32'h10, 32'h0}),
    .SLAVE_LIMIT   ({32'h20, 32'h10}),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .aclk        (aclk),
    .areset      (areset),
    .m_arvalid   (m_arvalid),
    .m_awvalid   (m_awvalid),
    .m_araddr    (m_araddr),
    .m_awaddr    (m_awaddr),
    .r_done      (r_done),
    .b_done      (b_done),
    .grant_valid (grant_valid),
    .grant_m     (grant_m),
    .grant_s     (grant_s),
    .grant_write (grant_write),
    .grant_decerr(grant_decerr),
    .timeout     (timeout)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  // Advance one edge and settle just after it.
  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  task automatic do_reset();
    areset = 1'b1;
    step();
    areset = 1'b0;
  endtask

  task automatic test_reset();
    areset    = 1'b1;
    m_arvalid = '0;
    m_awvalid = '0;
    m_araddr  = '0;
    m_awaddr  = '0;
    r_done    = 1'b0;
    b_done    = 1'b0;
    step();
    n_checks++;
    if ({grant_valid, grant_m, grant_s, grant_write, grant_decerr, timeout} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b required 000000",
               {grant_valid, grant_m, grant_s, grant_write, grant_decerr, timeout});
    end
    areset = 1'b0;
  endtask

  task automatic test_single_read();
    m_arvalid[0]     = 1'b1;
    m_araddr[31:0]   = 32'h4;
    step();
    n_checks++;
    if ({grant_valid, grant_m, grant_s, grant_write, grant_decerr} !== 5'b10000) begin
      n_fail++;
      $display("FAIL single_read_grant: got v/m/s/w/e=%b required 10000",
               {grant_valid, grant_m, grant_s, grant_write, grant_decerr});
    end
    m_arvalid = '0;
    step();
    step();
    n_checks++;
    if (grant_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL single_read_hold: got grant_valid=%b required 1", grant_valid);
    end
    r_done = 1'b1;
    step();
    r_done = 1'b0;
    n_checks++;
    if ({grant_valid, timeout} !== 2'b00) begin
      n_fail++;
      $display("FAIL single_read_release: got valid/timeout=%b required 00", {grant_valid, timeout});
    end
  endtask

  task automatic test_round_robin();
    logic [0:0] exp_m;
    do_reset();
    m_arvalid       = 2'b11;
    m_araddr[31:0]  = 32'h14;
    m_araddr[63:32] = 32'h14;
    for (int i = 0; i < 4; i++) begin
      exp_m = 1'(i % 2);
      step();
      n_checks++;
      if ({grant_valid, grant_m, grant_s, grant_write} !== {1'b1, exp_m, 1'b1, 1'b0}) begin
        n_fail++;
        $display("FAIL round_robin_%0d: got v/m/s/w=%b required %b", i,
                 {grant_valid, grant_m, grant_s, grant_write}, {1'b1, exp_m, 1'b1, 1'b0});
      end
      r_done = 1'b1;
      if (i == 3) m_arvalid = '0;
      step();
      r_done = 1'b0;
      n_checks++;
      if (grant_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL round_robin_release_%0d: got grant_valid=%b required 0", i, grant_valid);
      end
    end
  endtask

  task automatic test_read_priority();
    m_arvalid[1]     = 1'b1;
    m_araddr[63:32]  = 32'h8;
    m_awvalid[1]     = 1'b1;
    m_awaddr[63:32]  = 32'h18;
    step();
    n_checks++;
    if ({grant_valid, grant_m, grant_s, grant_write, grant_decerr} !== 5'b11000) begin
      n_fail++;
      $display("FAIL prio_read_grant: got v/m/s/w/e=%b required 11000",
               {grant_valid, grant_m, grant_s, grant_write, grant_decerr});
    end
    m_arvalid[1] = 1'b0;
    r_done       = 1'b1;
    step();
    r_done = 1'b0;
    step();
    n_checks++;
    if ({grant_valid, grant_m, grant_s, grant_write, grant_decerr} !== 5'b11110) begin
      n_fail++;
      $display("FAIL prio_write_grant: got v/m/s/w/e=%b required 11110",
               {grant_valid, grant_m, grant_s, grant_write, grant_decerr});
    end
    m_awvalid[1] = 1'b0;
    b_done       = 1'b1;
    step();
    b_done = 1'b0;
    n_checks++;
    if (grant_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL prio_write_release: got grant_valid=%b required 0", grant_valid);
    end
  endtask

  task automatic test_decode_miss();
    m_awvalid[0]   = 1'b1;
    m_awaddr[31:0] = 32'h40;
    step();
    n_checks++;
    if ({grant_valid, grant_m, grant_s, grant_write, grant_decerr} !== 5'b10011) begin
      n_fail++;
      $display("FAIL decerr_grant: got v/m/s/w/e=%b required 10011",
               {grant_valid, grant_m, grant_s, grant_write, grant_decerr});
    end
    m_awvalid = '0;
    r_done    = 1'b1;
    step();
    r_done = 1'b0;
    n_checks++;
    if ({grant_valid, grant_decerr} !== 2'b11) begin
      n_fail++;
      $display("FAIL decerr_ignore_rdone: got valid/decerr=%b required 11", {grant_valid, grant_decerr});
    end
    step();
    b_done = 1'b1;
    step();
    b_done = 1'b0;
    n_checks++;
    if (grant_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL decerr_release: got grant_valid=%b required 0", grant_valid);
    end
  endtask

  task automatic test_watchdog();
    logic held_ok;
    m_arvalid[1]    = 1'b1;
    m_araddr[63:32] = 32'h14;
    step();
    m_arvalid = '0;
    n_checks++;
    if ({grant_valid, grant_m} !== 2'b11) begin
      n_fail++;
      $display("FAIL wdog_grant: got valid/m=%b required 11", {grant_valid, grant_m});
    end
    held_ok = 1'b1;
    for (int k = 1; k < 8; k++) begin
      step();
      if (grant_valid !== 1'b1 || timeout !== 1'b0) held_ok = 1'b0;
    end
    n_checks++;
    if (held_ok !== 1'b1) begin
      n_fail++;
      $display("FAIL wdog_hold: got early release or timeout, required hold for 7 cycles");
    end
    step();
    n_checks++;
    if ({grant_valid, timeout} !== 2'b01) begin
      n_fail++;
      $display("FAIL wdog_fire: got valid/timeout=%b required 01", {grant_valid, timeout});
    end
    step();
    n_checks++;
    if ({grant_valid, timeout} !== 2'b00) begin
      n_fail++;
      $display("FAIL wdog_pulse_width: got valid/timeout=%b required 00", {grant_valid, timeout});
    end
    // Second run: done on the limit cycle beats the watchdog.
    m_arvalid[0]   = 1'b1;
    m_araddr[31:0] = 32'h4;
    step();
    m_arvalid = '0;
    n_checks++;
    if ({grant_valid, grant_m} !== 2'b10) begin
      n_fail++;
      $display("FAIL wdog2_grant: got valid/m=%b required 10", {grant_valid, grant_m});
    end
    for (int k = 1; k < 8; k++) step();
    r_done = 1'b1;
    step();
    r_done = 1'b0;
    n_checks++;
    if ({grant_valid, timeout} !== 2'b00) begin
      n_fail++;
      $display("FAIL wdog2_done_wins: got valid/timeout=%b required 00", {grant_valid, timeout});
    end
    step();
    n_checks++;
    if (timeout !== 1'b0) begin
      n_fail++;
      $display("FAIL wdog2_no_late_timeout: got timeout=%b required 0", timeout);
    end
  endtask

  task automatic test_async_reset();
    m_awvalid[0]   = 1'b1;
    m_awaddr[31:0] = 32'h18;
    step();
    m_awvalid = '0;
    n_checks++;
    if ({grant_valid, grant_m, grant_s, grant_write} !== 4'b1011) begin
      n_fail++;
      $display("FAIL areset_pre_grant: got v/m/s/w=%b required 1011",
               {grant_valid, grant_m, grant_s, grant_write});
    end
    #2;
    areset = 1'b1;
    #1;
    n_checks++;
    if ({grant_valid, grant_m, grant_s, grant_write, grant_decerr, timeout} !== 6'b0) begin
      n_fail++;
      $display("FAIL areset_immediate: got %b required 000000",
               {grant_valid, grant_m, grant_s, grant_write, grant_decerr, timeout});
    end
    #1;
    areset = 1'b0;
    m_arvalid       = 2'b11;
    m_araddr[31:0]  = 32'h4;
    m_araddr[63:32] = 32'h4;
    step();
    n_checks++;
    if ({grant_valid, grant_m, grant_write} !== 3'b100) begin
      n_fail++;
      $display("FAIL areset_ptr_restart: got v/m/w=%b required 100", {grant_valid, grant_m, grant_write});
    end
    r_done = 1'b1;
    step();
    r_done = 1'b0;
    step();
    n_checks++;
    if ({grant_valid, grant_m} !== 2'b11) begin
      n_fail++;
      $display("FAIL areset_next_master: got valid/m=%b required 11", {grant_valid, grant_m});
    end
    m_arvalid = '0;
    r_done    = 1'b1;
    step();
    r_done = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_round_robin();
    test_read_priority();
    test_decode_miss();
    test_watchdog();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Guard against a stalled run.
  initial begin
    #100000;
    $display("FAIL sim_time_limit: got no finish required finish before 100000");
    $fatal(1);
  end

endmodule
